// File: rtl/flash_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : flash_arb_pkg
//  Purpose  : Shared types and constants for the flash read arbiter:
//             FSM state encoding, default address/data widths and an
//             index-width helper.
//  Revision : 1.0 - initial release
// ============================================================================
package flash_arb_pkg;

   localparam int FLASH_ADDR_W = 16;
   localparam int FLASH_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Width needed to hold an index 0..n-1, never less than one bit
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/flash_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_picker
//  Purpose  : Combinational round-robin search. Returns the first asserted
//             request at or after ptr, wrapping modulo NUM_REQ.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_picker
   import flash_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
)(
   input  logic [NUM_REQ-1:0]              req,
   input  logic [idx_width(NUM_REQ)-1:0]   ptr,
   output logic                            any,
   output logic [idx_width(NUM_REQ)-1:0]   idx
);

   localparam int IDX_W = idx_width(NUM_REQ);

   int w_j;

   // Scan from ptr upward; the first hit wins and later hits are ignored
   always_comb begin
      any = 1'b0;
      idx = '0;
      w_j = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_j = int'(ptr) + k;
         if (w_j >= NUM_REQ) begin
            w_j = w_j - NUM_REQ;
         end
         if (!any && w_j < NUM_REQ && req[w_j]) begin
            any = 1'b1;
            idx = IDX_W'(w_j);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/flash_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : flash_arbiter
//  Purpose  : Shares one flash memory controller between NUM_REQ read
//             requesters. Round-robin grant, one read outstanding, sequences
//             the fmc start/ready handshake and routes data back.
//  Options  : FLASH_ARB_TIMEOUT_EN - adds a WAIT-state watchdog that returns
//             resp_err=1 / resp_data=0 after TIMEOUT_CYCLES without fmc_ready.
//  Revision : 1.0 - initial release
// ============================================================================
module flash_arbiter
   import flash_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_W         = FLASH_ADDR_W,
   parameter int DATA_W         = FLASH_DATA_W,
   parameter int TIMEOUT_CYCLES = 64
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [NUM_REQ-1:0]          resp_valid,
   output logic [DATA_W-1:0]           resp_data,
   output logic                        resp_err,
   output logic                        fmc_start,
   output logic [ADDR_W-1:0]           fmc_address,
   input  logic                        fmc_ready,
   input  logic [DATA_W-1:0]           fmc_data,
   output logic                        busy
);

   localparam int IDX_W = idx_width(NUM_REQ);

   state_t              r_state;
   state_t              w_next;
   logic [IDX_W-1:0]    r_rr_ptr;
   logic [IDX_W-1:0]    r_gnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_data;

   logic                w_any;
   logic [IDX_W-1:0]    w_idx;
   logic                w_accept;
   logic                w_finish;
   logic                w_timeout;
   logic [IDX_W-1:0]    w_ptr_next;

   rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req     (req_valid),
      .ptr     (r_rr_ptr),
      .any     (w_any),
      .idx     (w_idx)
   );

   assign w_accept   = (r_state == IDLE) && w_any;
   assign w_finish   = (r_state == WAIT) && (fmc_ready || w_timeout);
   assign w_ptr_next = (r_gnt == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt + IDX_W'(1);

`ifdef FLASH_ARB_TIMEOUT_EN
   localparam int CNT_W = idx_width(TIMEOUT_CYCLES);

   logic [CNT_W-1:0]    r_wd_cnt;
   logic                r_err;

   // A real fmc_ready in the final watchdog cycle still wins over the timeout
   assign w_timeout = (r_state == WAIT) && !fmc_ready &&
                      (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Watchdog: cleared outside WAIT so it starts at zero on WAIT entry
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wd_cnt <= '0;
         r_err    <= 1'b0;
      end else begin
         r_err <= w_timeout;
         if (r_state != WAIT) begin
            r_wd_cnt <= '0;
         end else begin
            r_wd_cnt <= r_wd_cnt + CNT_W'(1);
         end
      end
   end

   assign resp_err = r_err;
`else
   assign w_timeout = 1'b0;
   assign resp_err  = 1'b0;
`endif

   // State, grant, address and returned-data registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_rr_ptr <= '0;
         r_gnt    <= '0;
         r_addr   <= '0;
         r_data   <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_addr <= req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
            r_gnt  <= w_idx;
         end
         if (w_finish) begin
            r_data   <= w_timeout ? '0 : fmc_data;
            r_rr_ptr <= w_ptr_next;
         end
      end
   end

   // Next-state logic and the combinational accept pulse
   always_comb begin
      w_next    = r_state;
      req_ready = '0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_next = ISSUE;
               // Held low during reset so no requester believes it was taken
               if (!rst) begin
                  req_ready[w_idx] = 1'b1;
               end
            end
         end
         ISSUE:   w_next = WAIT;
         WAIT: begin
            if (fmc_ready || w_timeout) begin
               w_next = RESP;
            end
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // One-hot response strobe toward the granted requester
   always_comb begin
      resp_valid = '0;
      if (r_state == RESP) begin
         resp_valid[r_gnt] = 1'b1;
      end
   end

   assign fmc_start   = (r_state == ISSUE);
   assign fmc_address = r_addr;
   assign resp_data   = r_data;
   assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_flash_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flash_arbiter
//  Purpose  : Self-checking bench for flash_arbiter (NUM_REQ=2). A vector
//             table drives whole read transactions; expected responses are
//             queued at accept and checked when resp_valid appears.
//  Options  : FLASH_ARB_TIMEOUT_EN enables the watchdog sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flash_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [31:0] req_addr;
   logic [1:0]  req_ready;
   logic [1:0]  resp_valid;
   logic [15:0] resp_data;
   logic        resp_err;
   logic        fmc_start;
   logic [15:0] fmc_address;
   logic        fmc_ready;
   logic [15:0] fmc_data;
   logic        busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0]  valid;
      logic [15:0] a0;
      logic [15:0] a1;
      int          delay;
      logic [15:0] data;
      logic        spur;
      int          gnt;
      int          wait_n;
   } vec_t;

   typedef struct {
      logic [1:0]  vld;
      logic [15:0] data;
      logic        err;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[15];

   flash_arbiter #(
      .NUM_REQ        (2),
      .ADDR_W         (16),
      .DATA_W         (16),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_ready   (req_ready),
      .resp_valid  (resp_valid),
      .resp_data   (resp_data),
      .resp_err    (resp_err),
      .fmc_start   (fmc_start),
      .fmc_address (fmc_address),
      .fmc_ready   (fmc_ready),
      .fmc_data    (fmc_data),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // Response monitor: every resp_valid must match the oldest queued expectation
   always @(negedge clk) begin : mon
      exp_t e;
      if (resp_valid !== 2'b00) begin
         if (sb.size() == 0) begin
            chk("unexpected_resp", {30'd0, resp_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("resp_valid", {30'd0, resp_valid}, {30'd0, e.vld});
            chk("resp_data",  {16'd0, resp_data},  {16'd0, e.data});
            chk("resp_err",   {31'd0, resp_err},   {31'd0, e.err});
         end
      end
   end

   // One complete read: accept, issue, wait, response
   task automatic run_vec(input vec_t v);
      int          n;
      logic [15:0] ea;
      exp_t        e;
      ea = (v.gnt == 0) ? v.a0 : v.a1;
      if (v.spur) begin
         @(negedge clk); #1;
         fmc_data  = 16'hDEAD;
         fmc_ready = 1'b1;
         @(negedge clk); #1;
         fmc_ready = 1'b0;
      end
      req_addr  = {v.a1, v.a0};
      req_valid = v.valid;
      n = 0;
      #1;
      while (req_ready == 2'b00 && n < 8) begin
         @(negedge clk); #1;
         n++;
      end
      chk("accept_wait", n, v.wait_n);
      if (n >= 8) begin
         req_valid = 2'b00;
         return;
      end
      chk("req_ready", {30'd0, req_ready}, {30'd0, 2'(1 << v.gnt)});
      e.vld  = 2'(1 << v.gnt);
      e.data = v.data;
      e.err  = 1'b0;
      sb.push_back(e);
      @(negedge clk); #1;
      req_valid[v.gnt] = 1'b0;
      chk("fmc_start",   {31'd0, fmc_start},   32'd1);
      chk("fmc_address", {16'd0, fmc_address}, {16'd0, ea});
      fmc_data  = 16'hDEAD;
      fmc_ready = v.spur;
      for (int i = 0; i < v.delay; i++) begin
         @(negedge clk); #1;
         fmc_ready = 1'b0;
         chk("addr_hold",  {16'd0, fmc_address}, {16'd0, ea});
         chk("start_once", {31'd0, fmc_start},   32'd0);
      end
      fmc_data  = v.data;
      fmc_ready = 1'b1;
      @(negedge clk); #1;
      fmc_ready = 1'b0;
      fmc_data  = 16'h0000;
      chk("resp_latency", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=hang want=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int n;
      exp_t e;
      vec_t v;

      vecs[0] = '{2'b01, 16'h0123, 16'h0000, 3, 16'hBEEF, 1'b0, 0, 0};
      vecs[1] = '{2'b10, 16'h0000, 16'h0ABC, 1, 16'h1111, 1'b0, 1, 1};
      vecs[2] = '{2'b11, 16'h0010, 16'h0020, 1, 16'hA001, 1'b0, 0, 1};
      vecs[3] = '{2'b11, 16'h0010, 16'h0020, 2, 16'hA002, 1'b0, 1, 1};
      vecs[4] = '{2'b11, 16'h0010, 16'h0020, 1, 16'hA003, 1'b0, 0, 1};
      vecs[5] = '{2'b11, 16'h0010, 16'h0020, 4, 16'hA004, 1'b0, 1, 1};
      for (int i = 0; i < 8; i++) begin
         vecs[6+i] = '{2'b10, 16'h0000, 16'h0100 + 16'(i), 1, 16'hC000 + 16'(i), 1'b0, 1, 1};
      end
      vecs[14] = '{2'b01, 16'h0F0F, 16'h0000, 2, 16'h7777, 1'b1, 0, 0};

      rst       = 1'b1;
      req_valid = 2'b00;
      req_addr  = '0;
      fmc_ready = 1'b0;
      fmc_data  = '0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready",   {30'd0, req_ready},   32'd0);
      chk("rst_resp_valid",  {30'd0, resp_valid},  32'd0);
      chk("rst_resp_data",   {16'd0, resp_data},   32'd0);
      chk("rst_resp_err",    {31'd0, resp_err},    32'd0);
      chk("rst_fmc_start",   {31'd0, fmc_start},   32'd0);
      chk("rst_fmc_address", {16'd0, fmc_address}, 32'd0);
      chk("rst_busy",        {31'd0, busy},        32'd0);
      #1 rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         run_vec(vecs[i]);
      end

      // Reset during WAIT aborts the read; a later fmc_ready is ignored
      req_addr  = {16'h0000, 16'h5555};
      req_valid = 2'b01;
      @(negedge clk); #1;
      chk("abort_accept", {30'd0, req_ready}, 32'd1);
      @(negedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk); #1;
      chk("abort_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk); #1;
      chk("abort_resp_valid",  {30'd0, resp_valid},  32'd0);
      chk("abort_resp_data",   {16'd0, resp_data},   32'd0);
      chk("abort_fmc_start",   {31'd0, fmc_start},   32'd0);
      chk("abort_fmc_address", {16'd0, fmc_address}, 32'd0);
      chk("abort_busy_low",    {31'd0, busy},        32'd0);
      @(negedge clk); #1;
      rst       = 1'b0;
      fmc_data  = 16'hBAD0;
      fmc_ready = 1'b1;
      @(negedge clk); #1;
      fmc_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("late_ready_resp", {30'd0, resp_valid}, 32'd0);
         chk("late_ready_busy", {31'd0, busy},       32'd0);
      end
      // Pointer is back at 0 after reset, so requester 0 wins a tie
      v = '{2'b11, 16'hA0A0, 16'hB0B0, 2, 16'h1234, 1'b0, 0, 0};
      run_vec(v);

`ifdef FLASH_ARB_TIMEOUT_EN
      req_addr  = {16'h0C0C, 16'h0000};
      req_valid = 2'b10;
      @(negedge clk); #1;
      chk("to_accept", {30'd0, req_ready}, 32'd2);
      e.vld  = 2'b10;
      e.data = 16'h0000;
      e.err  = 1'b1;
      sb.push_back(e);
      @(negedge clk); #1;
      req_valid = 2'b00;
      n = 0;
      while (resp_valid == 2'b00 && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      chk("to_wait_cycles", n, 9);
      @(negedge clk); #1;
      chk("to_err_clear", {31'd0, resp_err}, 32'd0);
      v = '{2'b01, 16'h4242, 16'h0000, 1, 16'h5A5A, 1'b0, 0, 0};
      run_vec(v);
`endif

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
